bram_fifo_ctrl: RTL and testbench

- FIFO controller that drives a single-port block RAM (addr/write/data in, registered data out; the RAM updates its read register only on non-write cycles).
- Arbitrates one RAM access per cycle between an upstream valid/ready write stream and prefetch reads into a 2-entry output skid buffer.
- Presents a valid/ready read stream downstream.
- Used as the packet/word buffer front-end between the NTS parser and the processing engines.

---
 rtl/bram_fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo_ctrl
//  Description : FIFO controller around a single-port block RAM, with a
//                2-entry output skid buffer and fair write/read arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_rd_valid,
    input  logic                    i_rd_ready,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic [ADDR_WIDTH+1:0]   o_count,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic                    o_ram_write,
    output logic [DATA_WIDTH-1:0]   o_ram_wdata,
    input  logic [DATA_WIDTH-1:0]   i_ram_rdata
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH       = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic                c_GRANT_READ  = 1'b0;
    localparam logic                c_GRANT_WRITE = 1'b1;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_count;
    logic                  r_rd_pending;
    logic [1:0]            r_skid_cnt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  r_last_grant;

    logic w_full;
    logic w_rd_eligible;
    logic w_wg;
    logic w_rg;
    logic w_contend;
    logic w_pop;

    assign w_full        = (r_ram_count == c_DEPTH);
    // A read may only be issued if its result is guaranteed a skid slot.
    assign w_rd_eligible = (r_ram_count != '0) &&
                           (({1'b0, r_skid_cnt} + {2'b00, r_rd_pending}) < 3'd2);

    assign o_wr_ready = !i_reset && !w_full &&
                        !(w_rd_eligible && (r_last_grant == c_GRANT_WRITE));
    assign w_wg       = i_wr_valid && o_wr_ready;
    assign w_rg       = w_rd_eligible && !w_wg;
    assign w_contend  = !i_reset && i_wr_valid && w_rd_eligible && !w_full;

    assign o_ram_write = w_wg;
    assign o_ram_addr  = w_wg ? r_wr_ptr : r_rd_ptr;
    assign o_ram_wdata = i_wr_data;

    assign o_rd_valid = (r_skid_cnt != 2'd0);
    assign o_rd_data  = r_head;
    assign w_pop      = o_rd_valid && i_rd_ready;

    assign o_count = {1'b0, r_ram_count}
                   + {{(ADDR_WIDTH+1){1'b0}}, r_rd_pending}
                   + {{ADDR_WIDTH{1'b0}}, r_skid_cnt};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_rd_pending <= 1'b0;
            r_skid_cnt   <= 2'd0;
            r_head       <= '0;
            r_tail       <= '0;
            r_last_grant <= c_GRANT_READ;
        end else begin
            if (w_wg) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rg) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wg, w_rg})
                2'b10:   r_ram_count <= r_ram_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_ram_count <= r_ram_count - (ADDR_WIDTH+1)'(1);
                default: r_ram_count <= r_ram_count;
            endcase
            r_rd_pending <= w_rg;
            if (w_contend) begin
                r_last_grant <= w_wg ? c_GRANT_WRITE : c_GRANT_READ;
            end

            // Skid buffer: RAM data lands one cycle after issue; pop and capture may coincide.
            case (r_skid_cnt)
                2'd0: begin
                    if (r_rd_pending) begin
                        r_head     <= i_ram_rdata;
                        r_skid_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_pop && r_rd_pending) begin
                        r_head <= i_ram_rdata;
                    end else if (w_pop) begin
                        r_skid_cnt <= 2'd0;
                    end else if (r_rd_pending) begin
                        r_tail     <= i_ram_rdata;
                        r_skid_cnt <= 2'd2;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (r_rd_pending) begin
                            r_tail <= i_ram_rdata;
                        end else begin
                            r_skid_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_fifo_ctrl
//  Description : Directed bench for bram_fifo_ctrl with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_fifo_ctrl;

    localparam int AW = 8;
    localparam int DW = 64;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [DW-1:0] i_wr_data;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [DW-1:0] o_rd_data;
    logic [AW+1:0] o_count;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_write;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] i_ram_rdata;

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] exp_q [$];
    logic          mon_en = 1'b0;
    logic          wr_done = 1'b0;
    int            err_cnt = 0;
    int            chk_cnt = 0;

    always #5 i_clk = ~i_clk;

    bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_valid  (i_wr_valid),
        .o_wr_ready  (o_wr_ready),
        .i_wr_data   (i_wr_data),
        .o_rd_valid  (o_rd_valid),
        .i_rd_ready  (i_rd_ready),
        .o_rd_data   (o_rd_data),
        .o_count     (o_count),
        .o_ram_addr  (o_ram_addr),
        .o_ram_write (o_ram_write),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata)
    );

    // Single-port RAM: read register only updates on non-write cycles.
    always @(posedge i_clk) begin
        if (o_ram_write) mem[o_ram_addr] <= o_ram_wdata;
        else             i_ram_rdata     <= mem[o_ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int n;
        n = 0;
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        while (!o_wr_ready && n < 1000) begin
            cyc();
            n++;
        end
        if (n >= 1000) chk("wr_timeout", {63'd0, o_wr_ready}, 64'd1);
        cyc();
        i_wr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        i_rd_ready = 1'b1;
        while (o_count != '0 && c < 2000) begin
            cyc();
            c++;
        end
        chk(tag, 64'(o_count), 64'd0);
    endtask

    // Scoreboard: head of the model queue must match o_rd_data whenever valid.
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_rd_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", {63'd0, o_rd_valid}, 64'd0);
                else                   chk("head_data", o_rd_data, exp_q[0]);
            end
            chk("count", 64'(o_count), 64'(exp_q.size()));
            if (i_reset) begin
                exp_q.delete();
            end else begin
                if (i_wr_valid && o_wr_ready) exp_q.push_back(i_wr_data);
                if (o_rd_valid && i_rd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   wrote;
        int   cycles;
        logic w;
        logic prevw;

        // Reset with a write offered: the controller must refuse it.
        i_reset    = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = 64'h1234;
        i_rd_ready = 1'b0;
        cyc();
        mon_en = 1'b1;
        chk("rst_wr_ready", {63'd0, o_wr_ready}, 64'd0);
        chk("rst_ram_write", {63'd0, o_ram_write}, 64'd0);
        cyc();
        i_reset    = 1'b0;
        i_wr_valid = 1'b0;
        #1;
        chk("rst_rd_valid", {63'd0, o_rd_valid}, 64'd0);
        chk("rst_rd_data", o_rd_data, 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_wr_ready_after", {63'd0, o_wr_ready}, 64'd1);

        // Single word latency: handshake in N, valid in N+3.
        i_rd_ready = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = 64'hA5;
        cyc();
        i_wr_valid = 1'b0;
        chk("lat_n1_valid", {63'd0, o_rd_valid}, 64'd0);
        chk("lat_n1_count", 64'(o_count), 64'd1);
        cyc();
        chk("lat_n2_valid", {63'd0, o_rd_valid}, 64'd0);
        chk("lat_n2_count", 64'(o_count), 64'd1);
        cyc();
        chk("lat_n3_valid", {63'd0, o_rd_valid}, 64'd1);
        chk("lat_n3_data", o_rd_data, 64'hA5);
        chk("lat_n3_count", 64'(o_count), 64'd1);
        cyc();
        chk("lat_after_count", 64'(o_count), 64'd0);
        chk("lat_after_valid", {63'd0, o_rd_valid}, 64'd0);

        // Fill to DEPTH+2, confirm full behaviour, then drain in order.
        i_rd_ready = 1'b0;
        for (int k = 0; k < 258; k++) push_word(64'(k));
        repeat (4) cyc();
        chk("full_count", 64'(o_count), 64'd258);
        chk("full_wr_ready", {63'd0, o_wr_ready}, 64'd0);
        i_wr_valid = 1'b1;
        i_wr_data  = 64'hDEAD;
        repeat (3) begin
            #1;
            chk("full_ram_write", {63'd0, o_ram_write}, 64'd0);
            cyc();
        end
        i_wr_valid = 1'b0;
        chk("full_count_hold", 64'(o_count), 64'd258);
        drain("full_drain");

        // Contention: 1000 words with both sides always active.
        i_rd_ready = 1'b0;
        for (int k = 0; k < 20; k++) push_word(64'h1000 + 64'(k));
        repeat (4) cyc();
        i_rd_ready = 1'b1;
        wrote  = 0;
        cycles = 0;
        prevw  = 1'b0;
        while (wrote < 1000 && cycles < 4000) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 64'h2000 + 64'(wrote);
            #1;
            w = o_ram_write;
            if (cycles > 8) chk("alternate", {63'd0, w ^ prevw}, 64'd1);
            prevw = w;
            if (w) wrote++;
            cycles++;
            @(posedge i_clk);
            #1;
        end
        i_wr_valid = 1'b0;
        chk("alt_words", 64'(wrote), 64'd1000);
        drain("alt_drain");

        // Random backpressure across two pointer wraps.
        fork
            begin
                for (int k = 0; k < 600; k++) push_word(64'h5A00_0000_0000_0000 | 64'(k * 7));
                wr_done = 1'b1;
            end
            begin
                for (int c = 0; c < 6000 && !(wr_done && o_count == '0); c++) begin
                    i_rd_ready = 1'($urandom_range(0, 1));
                    cyc();
                end
            end
        join
        chk("rand_drain", 64'(o_count), 64'd0);

        // Reset with 10 words held and a RAM read in flight.
        i_rd_ready = 1'b0;
        for (int k = 0; k < 11; k++) push_word(64'h300 + 64'(k));
        repeat (4) cyc();
        i_rd_ready = 1'b1;
        cyc();
        i_rd_ready = 1'b0;
        cyc();
        chk("mid_held", 64'(o_count), 64'd10);
        i_reset = 1'b1;
        #1;
        chk("mid_rst_wr_ready", {63'd0, o_wr_ready}, 64'd0);
        cyc();
        i_reset = 1'b0;
        #1;
        chk("mid_rd_valid", {63'd0, o_rd_valid}, 64'd0);
        chk("mid_count", 64'(o_count), 64'd0);
        chk("mid_wr_ready", {63'd0, o_wr_ready}, 64'd1);
        push_word(64'h77);
        push_word(64'h78);
        for (int c = 0; c < 20 && !o_rd_valid; c++) cyc();
        chk("mid_first_word", o_rd_data, 64'h77);
        drain("mid_drain");

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
